led_frame_sequencer: RTL and testbench
======================================

Name: led_frame_sequencer

Overview:
- Frame-level controller for the LED backlight chain. It walks pixel addresses 0..NUM_LEDS-1 and fetches one 24-bit GRB word per LED from a pixel source using a request/valid handshake.
- Each word goes to the WS2812-style serializer through a start/busy handshake. After the last LED it holds a latch gap, then signals frame completion.
- Sits between the colour-extraction/buffer logic and the bit-level LED driver.

Parameters:
- NUM_LEDS, 100, LEDs per frame (2..2^ADDR_W).
- ADDR_W, 7, pixel address width.
- LATCH_CYCLES, 6000, clk cycles of latch gap after the last LED (>=2).
- PIX_TIMEOUT, 64, max cycles to wait for pix_valid after pix_req (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- frame_start  in  1  request to send one frame; sampled only in IDLE.
- auto_run  in  1  1 = restart a new frame immediately after the latch gap.
- pix_addr  out  ADDR_W  LED index being fetched.
- pix_req  out  1  one-cycle fetch request for pix_addr.
- pix_data  in  24  GRB word from the source.
- pix_valid  in  1  pix_data valid; honoured only in WAIT_PIX.
- tx_data  out  24  GRB word to the serializer; stable from tx_start until the next capture.
- tx_start  out  1  one-cycle start pulse to the serializer.
- tx_busy  in  1  serializer busy.
- frame_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- err_timeout  out  1  sticky flag: a pixel fetch timed out.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; all outputs and counters are 0.
  - Reset mid-frame aborts immediately: no tx_start and no frame_done are issued afterwards.
- All outputs are registered.
- States: IDLE, REQ, WAIT_PIX, SEND, WAIT_TX, LATCH.
- IDLE:
  - frame_start=1 → pix_addr<=0, err_timeout<=0, go to REQ.
  - frame_start outside IDLE is ignored.
- REQ:
  - pix_req=1 for exactly this cycle; the pix_addr shown is the one being fetched.
  - Wait timer cleared; go to WAIT_PIX.
- WAIT_PIX:
  - pix_valid=1 → tx_data<=pix_data, go to SEND.
  - Otherwise the timer increments. When the timer reaches PIX_TIMEOUT-1 with no valid, tx_data<=24'h0, err_timeout<=1, go to SEND (the LED is blanked, not skipped).
  - pix_valid on the timeout cycle wins: the data is captured and no error is raised.
- SEND:
  - tx_busy=0 → tx_start=1 for one cycle, go to WAIT_TX.
  - tx_busy=1 → hold state and data.
- WAIT_TX:
  - The first cycle is a guard cycle and tx_busy is ignored; the serializer must raise tx_busy within 1 cycle of tx_start.
  - From the second cycle, on tx_busy=0: if pix_addr==NUM_LEDS-1, load the latch counter and go to LATCH; else pix_addr<=pix_addr+1 and go to REQ.
- LATCH:
  - Counts LATCH_CYCLES cycles. pix_req and tx_start stay 0.
  - On the final cycle frame_done=1.
  - Next state is REQ with pix_addr=0 if auto_run=1 on that final cycle; otherwise IDLE.
  - err_timeout is kept across auto_run frames.
- Minimum time per LED is 5 cycles: REQ, 1 cycle in WAIT_PIX, SEND, and 2 cycles in WAIT_TX.
- Latency: frame_start at cycle N → pix_req at N+1 → earliest pix_valid accepted at N+2.
- pix_addr never exceeds NUM_LEDS-1 and never wraps mid-frame.
- pix_valid outside WAIT_PIX is dropped silently.

Test Plan:
Bench parameters: NUM_LEDS=3, LATCH_CYCLES=10, PIX_TIMEOUT=8.
- Basic frame: one frame_start pulse; source returns 0x112233, 0x445566, 0x778899 one cycle after each pix_req; serializer busy for 4 cycles after each start → exactly 3 tx_start pulses carrying those words in order, pix_addr 0,1,2, frame_done once, 10 cycles after the last tx_busy fall, then frame_busy=0.
- Timeout: source never answers LED 1 → tx_data=0 for LED 1, err_timeout=1 stays set to the end of the frame, LEDs 0 and 2 are correct, and the frame completes.
- Busy backpressure: tx_busy held 1 for 20 cycles on entry to SEND → tx_start is withheld until the cycle tx_busy drops, and tx_data is unchanged throughout.
- Ignored starts and stray valids: frame_start pulsed mid-frame and pix_valid pulsed during LATCH → no second frame and no data change; after IDLE, a new frame_start clears err_timeout.
- auto_run=1 → after frame_done the next cycle is REQ with pix_addr=0; 3 consecutive frames are produced with no IDLE cycle between them.
- Reset mid-operation: rst=0 during WAIT_TX of LED 1 → the next cycle shows all outputs 0 and IDLE; with rst=1 and no frame_start, no further tx_start or frame_done appears.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for the LED chain. It fetches one GRB word per LED, hands each word
// to the bit serializer, then holds the latch gap and pulses frame_done.
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 100,
  parameter int ADDR_W       = 7,
  parameter int LATCH_CYCLES = 6000,
  parameter int PIX_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              auto_run,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_req,
  input  logic [23:0]       pix_data,
  input  logic              pix_valid,
  output logic [23:0]       tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              err_timeout
);
  localparam int TW = $clog2(PIX_TIMEOUT);
  localparam int LW = $clog2(LATCH_CYCLES);
  localparam logic [TW-1:0]     TMAX = TW'(PIX_TIMEOUT - 1);
  localparam logic [LW-1:0]     LMAX = LW'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_PIX, SEND, WAIT_TX, LATCH} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [LW-1:0]     lcnt, lcnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [23:0]       data_nx;
  logic              err_nx, start_nx, done_nx, req_nx, busy_nx;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    lcnt_nx  = lcnt;
    addr_nx  = pix_addr;
    data_nx  = tx_data;
    err_nx   = err_timeout;
    start_nx = 1'b0;
    case (state)
      IDLE: if (frame_start) begin
        addr_nx  = '0;
        err_nx   = 1'b0;
        state_nx = REQ;
      end
      REQ: begin
        timer_nx = '0;
        state_nx = WAIT_PIX;
      end
      WAIT_PIX: begin
        if (pix_valid) begin
          data_nx  = pix_data;
          state_nx = SEND;
        end else if (timer == TMAX) begin
          // Blank the LED rather than skip it so the chain length stays intact.
          data_nx  = 24'h0;
          err_nx   = 1'b1;
          state_nx = SEND;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      SEND: if (!tx_busy) begin
        start_nx = 1'b1;
        state_nx = WAIT_TX;
      end
      // tx_start is high only in the first WAIT_TX cycle, so it doubles as the guard flag.
      WAIT_TX: if (!tx_start && !tx_busy) begin
        if (pix_addr == LAST) begin
          lcnt_nx  = LMAX;
          state_nx = LATCH;
        end else begin
          addr_nx  = pix_addr + ADDR_W'(1);
          state_nx = REQ;
        end
      end
      LATCH: begin
        if (lcnt == '0) begin
          if (auto_run) begin
            addr_nx  = '0;
            state_nx = REQ;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          lcnt_nx = lcnt - LW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    req_nx  = (state_nx == REQ);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == LATCH) && (lcnt_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      lcnt        <= '0;
      pix_addr    <= '0;
      pix_req     <= 1'b0;
      tx_data     <= 24'h0;
      tx_start    <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      lcnt        <= lcnt_nx;
      pix_addr    <= addr_nx;
      pix_req     <= req_nx;
      tx_data     <= data_nx;
      tx_start    <= start_nx;
      frame_busy  <= busy_nx;
      frame_done  <= done_nx;
      err_timeout <= err_nx;
    end
  end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: a behavioural pixel source and serializer
// drive the DUT, stimulus pushes expected words, a monitor pops and compares.
module tb_led_frame_sequencer;
  localparam int NL = 3, AW = 2, LC = 10, PT = 8;

  logic          clk = 0, rst = 0, frame_start = 0, auto_run = 0;
  logic [AW-1:0] pix_addr;
  logic          pix_req, pix_valid, tx_start, frame_busy, frame_done, err_timeout;
  logic [23:0]   pix_data, tx_data;
  logic          tx_busy = 0;
  logic          src_valid = 0, stray_req = 0;
  logic [23:0]   src_data = 0;

  assign pix_valid = src_valid | stray_req;
  assign pix_data  = stray_req ? 24'hDEAD00 : src_data;

  led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_W(AW), .LATCH_CYCLES(LC), .PIX_TIMEOUT(PT)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .auto_run(auto_run),
    .pix_addr(pix_addr), .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_busy(frame_busy), .frame_done(frame_done), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct { int addr; int data; int lat; } tx_exp_t;
  tx_exp_t exp_q[$];
  int      done_q[$];

  // Per-LED source behaviour: dly = cycles from pix_req to pix_valid, 0 = never answers.
  int          dly [NL];
  logic [23:0] word [NL];
  int          bp_led = -1;

  // Environment: serializer (busy 4 cycles per start, optional 20-cycle hold on SEND entry)
  int          busy_cnt = 0, cd = 0, pend_addr = 0, prev_valid_addr = -1;
  int          valid_cyc = 0, fall_cyc = 0, bp_active = 0;
  logic [23:0] pend_word = 0, bp_word = 0;
  logic        was_busy;
  always @(negedge clk) begin
    was_busy = tx_busy;
    if (busy_cnt > 0) busy_cnt--;
    if (tx_start) busy_cnt = 4;
    if (prev_valid_addr >= 0 && prev_valid_addr == bp_led) begin
      busy_cnt  = 20;
      bp_active = 1;
      bp_word   = word[bp_led];
    end
    if (bp_active != 0 && busy_cnt == 10) begin
      chk("tx_data held under busy", int'(tx_data), int'(bp_word));
      bp_active = 0;
    end
    tx_busy = (busy_cnt > 0);
    if (was_busy && !tx_busy) fall_cyc = cyc;
    src_valid       = 0;
    prev_valid_addr = -1;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        src_valid       = 1;
        src_data        = pend_word;
        valid_cyc       = cyc;
        prev_valid_addr = pend_addr;
      end
    end
    if (pix_req) begin
      cd        = dly[pix_addr];
      pend_word = word[pix_addr];
      pend_addr = int'(pix_addr);
    end
  end

  // Monitor
  int      tx_cnt = 0, done_cnt = 0, frame_tx = 0;
  logic    post_done = 0, exp_restart = 0;
  tx_exp_t e;
  int      ed;
  always @(negedge clk) begin
    if (post_done) begin
      post_done = 0;
      if (exp_restart) begin
        chk("restart pix_req", int'(pix_req), 1);
        chk("restart pix_addr", int'(pix_addr), 0);
        chk("restart frame_busy", int'(frame_busy), 1);
      end else begin
        chk("idle after done frame_busy", int'(frame_busy), 0);
      end
    end
    if (!rst) frame_tx = 0;
    if (tx_start) begin
      tx_cnt++;
      frame_tx++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected tx_start: addr=%0d data=0x%0h, expected none", pix_addr, tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx pix_addr", int'(pix_addr), e.addr);
        chk("tx data", int'(tx_data), e.data);
        if (e.lat >= 0) chk("valid-to-start latency", cyc - valid_cyc, e.lat);
      end
    end
    if (frame_done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected frame_done at cycle %0d, expected none", cyc);
      end else begin
        ed = done_q.pop_front();
        chk("done err_timeout", int'(err_timeout), ed);
        chk("latch gap after busy fall", cyc - fall_cyc, LC);
        chk("tx_start per frame", frame_tx, NL);
      end
      frame_tx    = 0;
      post_done   = 1;
      exp_restart = auto_run;
    end
  end

  task automatic led(input int i, input logic [23:0] w, input int d);
    word[i] = w;
    dly[i]  = d;
  endtask

  task automatic expect_leds(input int n);
    tx_exp_t t;
    for (int i = 0; i < n; i++) begin
      t.addr = i;
      if (dly[i] == 0 || dly[i] > PT) begin
        t.data = 0; t.lat = -1;
      end else begin
        t.data = int'(word[i]); t.lat = (i == bp_led) ? 22 : 2;
      end
      exp_q.push_back(t);
    end
  endtask

  task automatic expect_frame();
    int err = 0;
    for (int i = 0; i < NL; i++) if (dly[i] == 0 || dly[i] > PT) err = 1;
    expect_leds(NL);
    done_q.push_back(err);
  endtask

  task automatic start_frame();
    @(negedge clk) frame_start = 1;
    @(negedge clk) frame_start = 0;
    chk("start pix_req", int'(pix_req), 1);
    chk("start pix_addr", int'(pix_addr), 0);
    chk("start frame_busy", int'(frame_busy), 1);
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 600 && done_cnt < target; n++) @(negedge clk);
    chk("frame completes", done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pix_addr"}, int'(pix_addr), 0);
    chk({tag, " pix_req"}, int'(pix_req), 0);
    chk({tag, " tx_data"}, int'(tx_data), 0);
    chk({tag, " tx_start"}, int'(tx_start), 0);
    chk({tag, " frame_busy"}, int'(frame_busy), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
    chk({tag, " err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    int base, idle_seen;
    for (int i = 0; i < NL; i++) begin dly[i] = 1; word[i] = 0; end
    rst = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1;
    @(negedge clk);

    // Basic frame
    led(0, 24'h112233, 1); led(1, 24'h445566, 1); led(2, 24'h778899, 1);
    expect_frame();
    start_frame();
    wait_done(1);
    chk("basic queue drained", exp_q.size(), 0);

    // Valid arriving on the timeout cycle is still captured
    led(0, 24'hA1A1A1, 8); led(1, 24'hA2A2A2, 8); led(2, 24'hA3A3A3, 8);
    expect_frame();
    start_frame();
    wait_done(2);

    // LED 1 never answers, LED 2 answers one cycle too late
    led(0, 24'h0F0F0F, 1); led(1, 24'h123456, 0); led(2, 24'h654321, 9);
    expect_frame();
    start_frame();
    wait_done(3);
    chk("err_timeout sticky in idle", int'(err_timeout), 1);

    // Ignored mid-frame start and stray valid in LATCH; new start clears the error
    led(0, 24'hB0B0B0, 1); led(1, 24'hB1B1B1, 1); led(2, 24'hB2B2B2, 1);
    expect_frame();
    base = tx_cnt;
    start_frame();
    chk("err cleared by new start", int'(err_timeout), 0);
    repeat (6) @(negedge clk);
    frame_start = 1;
    @(negedge clk) frame_start = 0;
    for (int n = 0; n < 300 && tx_cnt < base + 3; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    for (int n = 0; n < 50 && tx_busy; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    stray_req = 1;
    @(negedge clk) stray_req = 0;
    @(negedge clk);
    chk("tx_data after stray valid", int'(tx_data), 24'hB2B2B2);
    chk("pix_req quiet in latch", int'(pix_req), 0);
    wait_done(4);
    repeat (15) @(negedge clk);
    chk("no second frame busy", int'(frame_busy), 0);
    chk("no second frame tx", tx_cnt, base + 3);

    // Serializer backpressure on LED 1
    bp_led = 1;
    led(0, 24'hC0C0C0, 1); led(1, 24'hC1C1C1, 1); led(2, 24'hC2C2C2, 1);
    expect_frame();
    start_frame();
    wait_done(5);
    bp_led = -1;

    // auto_run: three back-to-back frames
    led(0, 24'hD0D0D0, 1); led(1, 24'hD1D1D1, 1); led(2, 24'hD2D2D2, 1);
    expect_frame(); expect_frame(); expect_frame();
    auto_run  = 1;
    idle_seen = 0;
    start_frame();
    for (int n = 0; n < 600 && done_cnt < 7; n++) begin
      @(negedge clk);
      if (!frame_busy) idle_seen++;
    end
    repeat (5) @(negedge clk);
    auto_run = 0;
    wait_done(8);
    chk("no idle between auto frames", idle_seen, 0);

    // Reset during WAIT_TX of LED 1
    led(0, 24'hE0E0E0, 1); led(1, 24'hE1E1E1, 1); led(2, 24'hE2E2E2, 1);
    expect_leds(2);
    base = tx_cnt;
    start_frame();
    for (int n = 0; n < 200 && !(tx_start && pix_addr == 2'd1); n++) @(negedge clk);
    chk("reached LED 1 tx_start", int'(tx_start), 1);
    rst = 0;
    @(negedge clk);
    check_all_zero("mid-frame reset");
    rst = 1;
    repeat (40) @(negedge clk);
    chk("no tx_start after reset", tx_cnt, base + 2);
    chk("no frame_done after reset", done_cnt, 8);
    chk("final queue drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
